de_regfile_scoreboard: RTL and testbench
========================================

Name: de_regfile_scoreboard

Overview:
Parametrised register file with a per-register scoreboard for the decode stage of the in-order RISC-V pipeline. It succeeds the fixed 32x32 file with its stall tied to zero.
- Tracks outstanding writers per register with saturating counters.
- Raises a RAW/saturation stall toward FE, bypasses WB data to the decode read ports, and supports squash and flush of in-flight writers.
- Sits between the FE latch decode logic and the DE latch; WB and AGEX drive its write and squash ports.

Parameters:
DBITS, 32, data width of each register
REGWORDS, 32, number of architectural registers
REGNOBITS, 5, register index width (clog2 of REGWORDS)
CNTBITS, 2, pending-counter width; at most 2^CNTBITS-1 outstanding writes per register
BYPASS, 1, 1 = WB write data forwarded to same-cycle reads; 0 = no forwarding
ZERO_REG, 1, 1 = register 0 hardwired to zero and never tracked

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high
dec_valid  in  1  decode slot holds a valid instruction
dec_rs1  in  REGNOBITS  source 1 index
dec_rs2  in  REGNOBITS  source 2 index
dec_rs1_used  in  1  instruction reads rs1
dec_rs2_used  in  1  instruction reads rs2
dec_rd  in  REGNOBITS  destination index
dec_wr_reg  in  1  instruction writes rd
dec_ready  out  1  no hazard; instruction may issue this cycle
dec_issue  out  1  dec_valid & dec_ready
rdata1  out  DBITS  rs1 value (bypassed when BYPASS=1)
rdata2  out  DBITS  rs2 value (bypassed when BYPASS=1)
wb_valid  in  1  WB writes wb_data to wb_rd
wb_rd  in  REGNOBITS  WB destination
wb_data  in  DBITS  WB data
sq_valid  in  1  an issued writer to sq_rd was squashed and will not write back
sq_rd  in  REGNOBITS  squashed destination
flush  in  1  clear all pending counters
err_underflow  out  1  sticky; a counter decremented at zero
stall_cycles  out  32  saturating count of cycles with dec_valid & ~dec_ready

Behaviour:
Reset values:
- Registers, counters, err_underflow and stall_cycles all clear to 0.
- dec_ready is therefore 1 after reset.
- Reset asserted mid-operation discards all pending state immediately.

Register write:
- At posedge when wb_valid, regs[wb_rd] <= wb_data.
- Writes to index 0 are ignored when ZERO_REG=1.

Reads (combinational):
- rdataN = 0 if rsN==0 and ZERO_REG=1.
- Else wb_data if BYPASS=1 & wb_valid & wb_rd==rsN.
- Else regs[rsN].

Hazard for source N (N = 1, 2):
- Condition: rsN_used & !(ZERO_REG & rsN==0) & pend[rsN]!=0.
- The hazard is cleared when all three hold: BYPASS=1, pend[rsN]==1, and wb_valid & wb_rd==rsN (the last writer completes this cycle).
- When rs1 and rs2 are the same register, each is evaluated independently with the same result.

Saturation stall:
- dec_wr_reg & dec_rd tracked & pend[dec_rd]==2^CNTBITS-1.

Ready and issue:
- dec_ready = no source hazard & no saturation stall. It is independent of dec_valid.
- dec_issue = dec_valid & dec_ready.

Counter update per register r at posedge:
- inc = dec_issue & dec_wr_reg & dec_rd==r & r tracked.
- dec = (wb_valid & wb_rd==r) + (sq_valid & sq_rd==r), range 0..2.
- pend[r] <= pend[r] + inc - dec, clamped at 0.
- A clamp sets err_underflow, which stays set until reset.
- inc and dec in the same cycle cancel.

Flush:
- All pend <= 0; the same-cycle inc is suppressed.
- A same-cycle WB still writes data and does not flag underflow.

stall_cycles:
- Increments when dec_valid & ~dec_ready.
- Holds at 0xFFFFFFFF.

Latency:
- Read and stall decisions: 0 cycles.
- Counter effects are visible the cycle after the posedge.

Test Plan:
- Reset, then issue ADD rd=5 (wr) → pend[5]=1. Next cycle, rs1=5 used with no WB → dec_ready=0, stall_cycles increments. Assert WB rd=5 data=0x1234 → dec_ready=1, rdata1=0x1234 same cycle.
- BYPASS=0, same sequence → stall persists through the WB cycle. The cycle after the WB, rdata1=0x1234 and dec_ready=1.
- Issue three writers to x7 (CNTBITS=2) → pend=3. A fourth writer to x7 → dec_ready=0. One WB to x7 → fourth writer issues the following cycle, pend stays 3.
- pend[9]=2; same cycle: issue writer x9, WB x9, squash x9 → pend[9]=1. Squash x9 twice more → pend 0, then err_underflow=1.
- ZERO_REG=1: issue writer rd=0, then read rs1=0 → pend[0] stays 0, dec_ready=1, rdata1=0. WB to x0 with 0xFFFF → rdata1 still 0.
- pend[3]=2, pend[4]=1; flush with a concurrent issue to x3 and WB x4=0xAA → all pend=0, regs[4]=0xAA, err_underflow=0. Assert reset mid-stall → dec_ready=1, stall_cycles=0.

Source files
------------

// File: rtl/de_regfile_scoreboard.sv
// Decode-stage register file with a per-register pending-writer scoreboard.
// Tracks outstanding writers per register in saturating counters, stalls the
// decode slot on RAW hazards or counter saturation, forwards WB data to the
// read ports (BYPASS=1), and supports squash and flush of in-flight writers.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   dec_valid/rs1/rs2/rd/...   decode-slot instruction description
//   dec_ready, dec_issue       hazard-free indication and actual issue
//   rdata1, rdata2             source operand values
//   wb_valid/wb_rd/wb_data     writeback port
//   sq_valid/sq_rd             squash of an issued writer
//   flush                      clear all pending counters
//   err_underflow              sticky counter-underflow flag
//   stall_cycles               saturating count of stalled valid cycles
module de_regfile_scoreboard #(
  parameter int unsigned DBITS     = 32,
  parameter int unsigned REGWORDS  = 32,
  parameter int unsigned REGNOBITS = 5,
  parameter int unsigned CNTBITS   = 2,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [REGNOBITS-1:0] dec_rs1,
  input  logic [REGNOBITS-1:0] dec_rs2,
  input  logic                 dec_rs1_used,
  input  logic                 dec_rs2_used,
  input  logic [REGNOBITS-1:0] dec_rd,
  input  logic                 dec_wr_reg,
  output logic                 dec_ready,
  output logic                 dec_issue,
  output logic [DBITS-1:0]     rdata1,
  output logic [DBITS-1:0]     rdata2,
  input  logic                 wb_valid,
  input  logic [REGNOBITS-1:0] wb_rd,
  input  logic [DBITS-1:0]     wb_data,
  input  logic                 sq_valid,
  input  logic [REGNOBITS-1:0] sq_rd,
  input  logic                 flush,
  output logic                 err_underflow,
  output logic [31:0]          stall_cycles
);

  localparam int unsigned CW = CNTBITS + 2;
  localparam logic [CNTBITS-1:0] PendMax = '1;

  logic [DBITS-1:0]   regs_q [REGWORDS];
  logic [CNTBITS-1:0] pend_q [REGWORDS];
  logic [CNTBITS-1:0] pend_d [REGWORDS];
  logic               err_q;
  logic [31:0]        stall_q;

  logic               hazard1, hazard2, sat_stall, underflow;
  logic [CW-1:0]      up_v, dn_v;

  // Register 0 is never tracked or written when hardwired to zero.
  function automatic logic tracked(input logic [REGNOBITS-1:0] idx);
    return !((ZERO_REG != 0) && (idx == '0));
  endfunction

  // Combinational reads with optional WB forwarding; x0 override wins.
  always_comb begin
    rdata1 = regs_q[dec_rs1];
    if ((BYPASS != 0) && wb_valid && (wb_rd == dec_rs1)) rdata1 = wb_data;
    if (!tracked(dec_rs1)) rdata1 = '0;
    rdata2 = regs_q[dec_rs2];
    if ((BYPASS != 0) && wb_valid && (wb_rd == dec_rs2)) rdata2 = wb_data;
    if (!tracked(dec_rs2)) rdata2 = '0;
  end

  // A source is clear if nothing is pending, or the only pending writer
  // completes this very cycle and its data is forwarded.
  always_comb begin
    hazard1 = dec_rs1_used && tracked(dec_rs1) && (pend_q[dec_rs1] != '0);
    if ((BYPASS != 0) && (pend_q[dec_rs1] == CNTBITS'(1)) && wb_valid && (wb_rd == dec_rs1))
      hazard1 = 1'b0;
    hazard2 = dec_rs2_used && tracked(dec_rs2) && (pend_q[dec_rs2] != '0);
    if ((BYPASS != 0) && (pend_q[dec_rs2] == CNTBITS'(1)) && wb_valid && (wb_rd == dec_rs2))
      hazard2 = 1'b0;
    sat_stall = dec_wr_reg && tracked(dec_rd) && (pend_q[dec_rd] == PendMax);
  end

  assign dec_ready     = !hazard1 && !hazard2 && !sat_stall;
  assign dec_issue     = dec_valid && dec_ready;
  assign err_underflow = err_q;
  assign stall_cycles  = stall_q;

  // Per-register counter next state: +issue, -WB, -squash, clamped at zero.
  always_comb begin
    pend_d    = pend_q;
    underflow = 1'b0;
    up_v      = '0;
    dn_v      = '0;
    for (int unsigned r = 0; r < REGWORDS; r++) begin
      up_v = {2'b00, pend_q[r]};
      dn_v = '0;
      if (tracked(REGNOBITS'(r))) begin
        if (dec_issue && dec_wr_reg && (dec_rd == REGNOBITS'(r))) up_v = up_v + CW'(1);
        if (wb_valid && (wb_rd == REGNOBITS'(r))) dn_v = dn_v + CW'(1);
        if (sq_valid && (sq_rd == REGNOBITS'(r))) dn_v = dn_v + CW'(1);
      end
      if (flush) begin
        pend_d[r] = '0;
      end else if (up_v < dn_v) begin
        pend_d[r] = '0;
        underflow = 1'b1;
      end else begin
        pend_d[r] = CNTBITS'(up_v - dn_v);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < REGWORDS; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      if (wb_valid && tracked(wb_rd)) regs_q[wb_rd] <= wb_data;
      for (int unsigned r = 0; r < REGWORDS; r++) pend_q[r] <= pend_d[r];
      if (underflow) err_q <= 1'b1;
      if (dec_valid && !dec_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_de_regfile_scoreboard.sv
// Directed bench for de_regfile_scoreboard: one BYPASS=1 instance (a_*) and
// one BYPASS=0 instance (b_*) sharing the same stimulus.
module tb_de_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_rs1_used, dec_rs2_used, dec_wr_reg;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd, sq_rd;
  logic        wb_valid, sq_valid, flush;
  logic [31:0] wb_data;

  logic        a_ready, a_issue, a_err, b_ready, b_issue, b_err;
  logic [31:0] a_rdata1, a_rdata2, a_stall, b_rdata1, b_rdata2, b_stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  de_regfile_scoreboard #(.BYPASS(1)) u_dut_a (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd),
    .dec_wr_reg(dec_wr_reg), .dec_ready(a_ready), .dec_issue(a_issue), .rdata1(a_rdata1),
    .rdata2(a_rdata2), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .sq_valid(sq_valid), .sq_rd(sq_rd), .flush(flush), .err_underflow(a_err),
    .stall_cycles(a_stall)
  );

  de_regfile_scoreboard #(.BYPASS(0)) u_dut_b (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd),
    .dec_wr_reg(dec_wr_reg), .dec_ready(b_ready), .dec_issue(b_issue), .rdata1(b_rdata1),
    .rdata2(b_rdata2), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .sq_valid(sq_valid), .sq_rd(sq_rd), .flush(flush), .err_underflow(b_err),
    .stall_cycles(b_stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic idle();
    dec_valid = 0; dec_rs1_used = 0; dec_rs2_used = 0; dec_wr_reg = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; wb_rd = 0; sq_rd = 0;
    wb_valid = 0; sq_valid = 0; flush = 0; wb_data = 0;
  endtask

  // Advance past one posedge, then let combinational outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic writer(input logic [4:0] rd);
    idle();
    dec_valid = 1; dec_wr_reg = 1; dec_rd = rd;
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #2;
    do_reset();
    check_eq("reset_ready_a", {31'd0, a_ready}, 32'd1);
    check_eq("reset_ready_b", {31'd0, b_ready}, 32'd1);
    check_eq("reset_stall", a_stall, 32'd0);
    check_eq("reset_err", {31'd0, a_err}, 32'd0);

    // RAW on x5, bypass vs no bypass
    writer(5'd5);
    check_eq("add_issue", {31'd0, a_issue}, 32'd1);
    tick();
    idle(); dec_valid = 1; dec_rs1 = 5; dec_rs1_used = 1; #1;
    check_eq("raw_ready_a", {31'd0, a_ready}, 32'd0);
    check_eq("raw_ready_b", {31'd0, b_ready}, 32'd0);
    tick();
    check_eq("raw_stall_a", a_stall, 32'd1);
    check_eq("raw_stall_b", b_stall, 32'd1);
    wb_valid = 1; wb_rd = 5; wb_data = 32'h1234; #1;
    check_eq("byp_ready_a", {31'd0, a_ready}, 32'd1);
    check_eq("byp_rdata_a", a_rdata1, 32'h1234);
    check_eq("nobyp_ready_b", {31'd0, b_ready}, 32'd0);
    tick();
    wb_valid = 0; wb_data = 0; #1;
    check_eq("after_wb_ready_b", {31'd0, b_ready}, 32'd1);
    check_eq("after_wb_rdata_b", b_rdata1, 32'h1234);
    check_eq("after_wb_stall_a", a_stall, 32'd1);
    check_eq("after_wb_stall_b", b_stall, 32'd2);
    tick();

    // Saturation on x7
    do_reset();
    writer(5'd7);
    tick(); tick(); tick();
    check_eq("sat_ready", {31'd0, a_ready}, 32'd0);
    tick();
    wb_valid = 1; wb_rd = 7; wb_data = 32'h77; #1;
    check_eq("sat_wb_ready", {31'd0, a_ready}, 32'd0);
    tick();
    wb_valid = 0; #1;
    check_eq("sat_release", {31'd0, a_issue}, 32'd1);
    tick();
    check_eq("sat_again", {31'd0, a_ready}, 32'd0);
    check_eq("sat_stall_cnt", a_stall, 32'd2);

    // Issue + WB + squash on x9, then underflow
    do_reset();
    writer(5'd9);
    tick(); tick();
    wb_valid = 1; wb_rd = 9; sq_valid = 1; sq_rd = 9; #1;
    check_eq("x9_triple_issue", {31'd0, a_issue}, 32'd1);
    tick();
    idle(); dec_valid = 1; dec_rs1 = 9; dec_rs1_used = 1; #1;
    check_eq("x9_pend_nonzero", {31'd0, a_ready}, 32'd0);
    wb_valid = 1; wb_rd = 9; #1;
    check_eq("x9_pend_one", {31'd0, a_ready}, 32'd1);
    idle(); sq_valid = 1; sq_rd = 9;
    tick();
    idle(); dec_rs1 = 9; dec_rs1_used = 1; #1;
    check_eq("x9_pend_zero", {31'd0, a_ready}, 32'd1);
    check_eq("x9_no_err", {31'd0, a_err}, 32'd0);
    idle(); sq_valid = 1; sq_rd = 9;
    tick();
    idle(); #1;
    check_eq("x9_underflow", {31'd0, a_err}, 32'd1);
    tick();
    check_eq("x9_err_sticky", {31'd0, a_err}, 32'd1);

    // x0 hardwired
    do_reset();
    check_eq("x0_err_cleared", {31'd0, a_err}, 32'd0);
    writer(5'd0);
    tick();
    idle(); dec_valid = 1; dec_rs1 = 0; dec_rs1_used = 1; #1;
    check_eq("x0_ready", {31'd0, a_ready}, 32'd1);
    check_eq("x0_rdata", a_rdata1, 32'd0);
    wb_valid = 1; wb_rd = 0; wb_data = 32'hFFFF; #1;
    check_eq("x0_wb_byp", a_rdata1, 32'd0);
    tick();
    wb_valid = 0; #1;
    check_eq("x0_after_wb", a_rdata1, 32'd0);

    // Flush with concurrent issue and WB
    do_reset();
    writer(5'd3); tick(); tick();
    writer(5'd4); tick();
    writer(5'd3); flush = 1; wb_valid = 1; wb_rd = 4; wb_data = 32'hAA;
    tick();
    idle(); dec_valid = 1; dec_rs1 = 3; dec_rs1_used = 1; dec_rs2 = 4; dec_rs2_used = 1; #1;
    check_eq("flush_ready", {31'd0, a_ready}, 32'd1);
    check_eq("flush_wb_data", a_rdata2, 32'hAA);
    check_eq("flush_no_err", {31'd0, a_err}, 32'd0);
    tick();
    writer(5'd4); tick();
    idle(); dec_valid = 1; dec_rs1 = 4; dec_rs1_used = 1; #1;
    check_eq("prestall_ready", {31'd0, a_ready}, 32'd0);
    tick(); tick();
    check_eq("prestall_cnt", a_stall, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midreset_ready", {31'd0, a_ready}, 32'd1);
    check_eq("midreset_stall", a_stall, 32'd0);
    tick();
    reset = 1'b0;
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
